// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the PLL reconfiguration sequencer:
// FSM state encoding, altpll_reconfig counter/param codes and the
// divide-factor to high/low count split.
package pll_reconfig_pkg;

  typedef enum logic [3:0] {
    ST_RESET_PLL,
    ST_RESET_REC,
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_RECONFIG,
    ST_WAIT_BUSY,
    ST_WAIT_LOCK,
    ST_DONE
  } pll_state_e;

  localparam logic [3:0] TYPE_M     = 4'b0001;
  localparam logic [3:0] TYPE_C0    = 4'b0100;
  localparam logic [2:0] PARAM_HIGH = 3'b000;
  localparam logic [2:0] PARAM_LOW  = 3'b001;

  typedef struct packed {
    logic [8:0] hi;
    logic [8:0] lo;
  } cnt_pair_t;

  typedef struct packed {
    logic [3:0] ctype;
    logic [2:0] cparam;
    logic [8:0] data;
  } wr_entry_t;

  // Split a divide factor into high/low phase counts; odd factors put
  // the extra cycle in the high phase. Bit 8 is always zero.
  function automatic cnt_pair_t calc_counts(input logic [7:0] f);
    cnt_pair_t  r;
    logic [8:0] f9;
    f9   = {1'b0, f};
    r.hi = (f9 + 9'd1) >> 1;
    r.lo = f9 >> 1;
    return r;
  endfunction

endpackage

// File: rtl/pll_reconfig_seq_wait_timer.sv
// Loadable down-counter. Loading N-1 on entry to a state and leaving
// when o_expired is seen gives a state length of exactly N cycles.
module wait_timer #(
  parameter int W = 4
) (
  input  logic         clock_ctr,
  input  logic         sys_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clock_ctr or posedge sys_reset) begin
    if (sys_reset)          r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: programs M and NUM_C post-scale
// counters through the altpll_reconfig port interface, fires reconfig
// and waits for the IP to finish, with factor checking and a busy
// timeout. Optional build macro PLL_LOCK_WAIT_EN adds i_pll_locked and
// a WAIT_LOCK step before DONE.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_C        = 2,
  parameter int SETUP_WAIT   = 5,
  parameter int WRITE_WAIT   = 10,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic               clock_ctr,
  input  logic               sys_reset,
  input  logic               i_start,
  input  logic [7:0]         i_mult_factor,
  input  logic [NUM_C*8-1:0] i_post_div,
  input  logic               i_busy_in,
`ifdef PLL_LOCK_WAIT_EN
  input  logic               i_pll_locked,
`endif
  output logic [3:0]         o_counter_type,
  output logic [2:0]         o_counter_param,
  output logic [8:0]         o_data_in,
  output logic               o_write_param,
  output logic               o_reconfig,
  output logic               o_reset_rec,
  output logic               o_pll_areset,
  output logic               o_pll_pfdena,
  output logic               o_ready,
  output logic               o_done,
  output logic               o_cfg_err,
  output logic               o_timeout_err
);

  localparam int NUM_ENT  = 2 * (NUM_C + 1);
  localparam int IDX_W    = $clog2(NUM_ENT);
  localparam int WAIT_MAX = (SETUP_WAIT > WRITE_WAIT) ? SETUP_WAIT : WRITE_WAIT;
  localparam int TM_W     = $clog2(WAIT_MAX + 1);
  localparam int TO_W     = $clog2(BUSY_TIMEOUT + 1);

  pll_state_e         r_state, w_nxt;
  logic [IDX_W-1:0]   r_idx, w_nidx, w_ci;
  logic [7:0]         r_mult;
  logic [NUM_C*8-1:0] r_post;
  logic [7:0]         w_m_src, w_fsel;
  logic [NUM_C*8-1:0] w_pd_src;
  logic               w_fact_ok;
  logic               w_last;
  logic               w_tm_load, w_tm_exp;
  logic [TM_W-1:0]    w_tm_val;
  logic [TO_W-1:0]    r_to_cnt;
  logic               w_to_max, w_to_hit, w_stall;
  logic               w_locked;
  cnt_pair_t          w_cnt;
  wr_entry_t          w_entry, r_entry;
  logic               r_write_param, r_reconfig, r_reset_rec, r_pll_areset;
  logic               r_ready, r_done, r_cfg_err, r_timeout_err;

`ifdef PLL_LOCK_WAIT_EN
  assign w_locked = i_pll_locked;
`else
  assign w_locked = 1'b1;
`endif

  // While idle the entry decode looks at the live inputs so the first
  // write can be set up on the same edge that latches them.
  assign w_m_src  = (r_state == ST_IDLE) ? i_mult_factor : r_mult;
  assign w_pd_src = (r_state == ST_IDLE) ? i_post_div    : r_post;
  assign w_last   = (r_idx == IDX_W'(NUM_ENT - 1));
  assign w_to_max = (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1));

  // A divide factor below 2 cannot be split into high/low phases.
  always_comb begin
    w_fact_ok = (i_mult_factor > 8'd1);
    for (int i = 0; i < NUM_C; i++)
      if (i_post_div[i*8 +: 8] < 8'd2) w_fact_ok = 1'b0;
  end

  // Index of the entry about to be set up: restart from 0 on a new
  // request, advance after each completed hold.
  always_comb begin
    w_nidx = r_idx;
    if (r_state == ST_IDLE)      w_nidx = '0;
    else if (r_state == ST_HOLD) w_nidx = r_idx + 1'b1;
  end

  // Decode entry w_nidx into counter type, param and count value.
  always_comb begin
    w_ci   = w_nidx >> 1;
    w_fsel = w_m_src;
    for (int i = 0; i < NUM_C; i++)
      if (w_ci == IDX_W'(i + 1)) w_fsel = w_pd_src[i*8 +: 8];
    w_cnt          = calc_counts(w_fsel);
    w_entry.ctype  = (w_ci == '0) ? TYPE_M : (TYPE_C0 + 4'(w_ci) - 4'd1);
    w_entry.cparam = w_nidx[0] ? PARAM_LOW : PARAM_HIGH;
    w_entry.data   = w_nidx[0] ? w_cnt.lo  : w_cnt.hi;
  end

  // Cycles that count toward the busy/lock timeout.
  always_comb begin
    w_stall = ((r_state == ST_HOLD) || (r_state == ST_WAIT_BUSY)) && i_busy_in;
`ifdef PLL_LOCK_WAIT_EN
    if ((r_state == ST_WAIT_LOCK) && !i_pll_locked) w_stall = 1'b1;
`endif
  end

  // Next-state logic; timeout wins over a normal exit in the wait states.
  always_comb begin
    w_nxt    = r_state;
    w_to_hit = 1'b0;
    case (r_state)
      ST_RESET_PLL: w_nxt = ST_RESET_REC;
      ST_RESET_REC: if (w_tm_exp) w_nxt = ST_IDLE;
      ST_IDLE:      if (i_start && w_fact_ok) w_nxt = ST_SETUP;
      ST_SETUP:     if (w_tm_exp) w_nxt = ST_WRITE;
      ST_WRITE:     w_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_stall && w_to_max) begin
          w_to_hit = 1'b1;
          w_nxt    = ST_RESET_PLL;
        end else if (w_tm_exp && !i_busy_in) begin
          w_nxt = w_last ? ST_RECONFIG : ST_SETUP;
        end
      end
      ST_RECONFIG:  w_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!i_busy_in) begin
`ifdef PLL_LOCK_WAIT_EN
          w_nxt = ST_WAIT_LOCK;
`else
          w_nxt = ST_DONE;
`endif
        end else if (w_to_max) begin
          w_to_hit = 1'b1;
          w_nxt    = ST_RESET_PLL;
        end
      end
`ifdef PLL_LOCK_WAIT_EN
      ST_WAIT_LOCK: begin
        if (w_locked) w_nxt = ST_DONE;
        else if (w_to_max) begin
          w_to_hit = 1'b1;
          w_nxt    = ST_RESET_PLL;
        end
      end
`endif
      ST_DONE:      w_nxt = ST_IDLE;
      default:      w_nxt = ST_RESET_PLL;
    endcase
  end

  // Reload the shared wait timer on every state entry with that state's length.
  always_comb begin
    w_tm_load = (w_nxt != r_state);
    case (w_nxt)
      ST_RESET_REC: w_tm_val = TM_W'(WRITE_WAIT - 1);
      ST_SETUP:     w_tm_val = TM_W'(SETUP_WAIT - 1);
      ST_HOLD:      w_tm_val = TM_W'(WRITE_WAIT - 1);
      default:      w_tm_val = '0;
    endcase
  end

  wait_timer #(.W(TM_W)) u_timer (
    .clock_ctr  (clock_ctr),
    .sys_reset  (sys_reset),
    .i_load     (w_tm_load),
    .i_load_val (w_tm_val),
    .o_expired  (w_tm_exp)
  );

  // State register plus outputs registered from the next state.
  always_ff @(posedge clock_ctr or posedge sys_reset) begin
    if (sys_reset) begin
      r_state       <= ST_RESET_PLL;
      r_idx         <= '0;
      r_mult        <= '0;
      r_post        <= '0;
      r_to_cnt      <= '0;
      r_entry       <= '0;
      r_write_param <= 1'b0;
      r_reconfig    <= 1'b0;
      r_reset_rec   <= 1'b0;
      r_pll_areset  <= 1'b1;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if ((r_state == ST_IDLE) && (w_nxt == ST_SETUP)) begin
        r_mult        <= i_mult_factor;
        r_post        <= i_post_div;
        r_timeout_err <= 1'b0;
      end
      if (w_to_hit) r_timeout_err <= 1'b1;
      if ((w_nxt == ST_SETUP) && (r_state != ST_SETUP)) begin
        r_idx   <= w_nidx;
        r_entry <= w_entry;
      end
      if (w_nxt != r_state) r_to_cnt <= '0;
      else if (w_stall)     r_to_cnt <= r_to_cnt + 1'b1;
      r_write_param <= (w_nxt == ST_WRITE);
      r_reconfig    <= (w_nxt == ST_RECONFIG);
      r_reset_rec   <= (w_nxt == ST_RESET_REC);
      r_pll_areset  <= (w_nxt == ST_RESET_PLL);
      r_ready       <= (w_nxt == ST_IDLE);
      r_done        <= (w_nxt == ST_DONE);
      r_cfg_err     <= (r_state == ST_IDLE) && i_start && !w_fact_ok;
    end
  end

  assign o_counter_type  = r_entry.ctype;
  assign o_counter_param = r_entry.cparam;
  assign o_data_in       = r_entry.data;
  assign o_write_param   = r_write_param;
  assign o_reconfig      = r_reconfig;
  assign o_reset_rec     = r_reset_rec;
  assign o_pll_areset    = r_pll_areset;
  assign o_pll_pfdena    = 1'b1;
  assign o_ready         = r_ready;
  assign o_done          = r_done;
  assign o_cfg_err       = r_cfg_err;
  assign o_timeout_err   = r_timeout_err;

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Parametrised successor of the single-M/single-C PLL reconfiguration controller.
- Drives the altpll_reconfig megafunction port interface to program the M counter and NUM_C post-scale counters (C0..C{NUM_C-1}) from latched divide factors, then fires reconfig and waits for completion.
- Adds a start/ready/done handshake, factor validation, configurable wait lengths and a busy timeout.
- Sits between the clock-setup register block and the PLL reconfig IP.

Parameters:
- NUM_C, 2, number of post-scale C counters programmed (1..8).
- SETUP_WAIT, 5, cycles type/param/data are held stable before write_param.
- WRITE_WAIT, 10, minimum cycles after a write_param pulse before the next step.
- BUSY_TIMEOUT, 1023, maximum cycles busy_in may stay high after reconfig before timeout_err.

Ports:
- clock_ctr  in  1  controller clock (reconfig IP clock)
- sys_reset  in  1  asynchronous, active-high reset
- start  in  1  request a reconfiguration; sampled only when ready=1
- mult_factor  in  8  M divide value
- post_div  in  NUM_C*8  C divide values, C0 in bits [7:0]
- busy_in  in  1  busy from reconfig IP
- counter_type  out  4  counter type select
- counter_param  out  3  000=high count, 001=low count
- data_in  out  9  count value; bit 8 always 0
- write_param  out  1  one-cycle write strobe
- reconfig  out  1  one-cycle reconfig strobe
- reset_rec  out  1  reconfig IP reset
- pll_areset  out  1  PLL asynchronous reset
- pll_pfdena  out  1  tied 1
- ready  out  1  idle, able to accept start
- done  out  1  one-cycle pulse on successful completion
- cfg_err  out  1  one-cycle pulse, start rejected
- timeout_err  out  1  sticky until next accepted start or reset

Behaviour:
- Reset values: state RESET_PLL; all strobes 0; ready=0; done=0; cfg_err=0; timeout_err=0; data_in=0; counter_type=0; counter_param=0; pll_pfdena=1.
- Reset sequence:
  - RESET_PLL: pll_areset=1 for 1 cycle.
  - RESET_REC: reset_rec=1 for WRITE_WAIT cycles.
  - Then IDLE with ready=1.
- IDLE, start=1 with any factor 0 or 1: no state change; cfg_err pulses on the next cycle.
- IDLE, start=1 with all factors valid:
  - Latch mult_factor and post_div.
  - Clear timeout_err.
  - ready drops the next cycle.
- Write list, index k = 0 .. 2*(NUM_C+1)-1, in this order:
  - M high, M low, C0 high, C0 low, and so on.
  - Type encoding: M=4'b0001, Ci=4'b0100+i.
  - Counts: high=(f+1)>>1, low=f>>1, zero-extended to 9 bits.
- Per entry:
  - SETUP: outputs stable for SETUP_WAIT cycles.
  - WRITE: write_param=1 for exactly 1 cycle.
  - HOLD: at least WRITE_WAIT cycles and until busy_in=0.
  - Then next entry.
- After the last entry:
  - RECONFIG: reconfig=1 for 1 cycle.
  - WAIT_BUSY: exit when busy_in=0, with a minimum of 1 cycle after reconfig.
  - DONE: done pulses 1 cycle, then IDLE.
- Timeout:
  - WAIT_BUSY or HOLD lasting BUSY_TIMEOUT cycles with busy_in=1 sets timeout_err.
  - Then goes to RESET_PLL (full re-initialise); done does not pulse.
- start outside IDLE is ignored; it is not queued.
- Input changes after latching have no effect.
- sys_reset mid-sequence aborts immediately to RESET_PLL; the partial write is abandoned.
- Outputs are registered, decoded from the next state, and glitch-free.

Optional Feature:
- Macro PLL_LOCK_WAIT_EN.
- Defined:
  - Adds input pll_locked (1 bit).
  - After WAIT_BUSY, enters WAIT_LOCK until pll_locked=1, then DONE.
  - The same BUSY_TIMEOUT limit applies; on expiry, timeout_err is set and the block goes to RESET_PLL.
- Undefined: no port; WAIT_BUSY goes directly to DONE.

Decomposition:
- Package pll_reconfig_pkg holds:
  - state enum.
  - counter-type constants (TYPE_M, TYPE_C0).
  - param constants (PARAM_HIGH, PARAM_LOW).
  - function computing high/low counts from an 8-bit factor.
- Sub-module wait_timer:
  - Loadable down-counter with load, load value and expired flag.
  - Single instance, shared by the SETUP, HOLD and reset waits.
  - Separate timeout counter in the top level.

Test Plan:
- Reset released, busy_in=0 → pll_areset pulses 1 cycle, reset_rec high 10 cycles, ready=1.
- NUM_C=2, start with M=8, C0=5, C1=2 → six writes, in order:
  - type 0001: param 000 data 4, then param 001 data 4.
  - type 0100: data 3, then data 2.
  - type 0101: data 1, then data 1.
  - Then one reconfig pulse; done after busy_in falls.
- start with C0=1 → cfg_err pulse, no write_param, ready stays 1.
- busy_in held high 1023 cycles after reconfig → timeout_err=1, no done, re-enters RESET_PLL; a later valid start clears timeout_err.
- sys_reset asserted during the third write → outputs to reset values within the same cycle, full reset sequence replays.
- start pulsed while busy → ignored; exactly one done per accepted start.
